spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_1000: SPI master register base; data register at BASE+0, control/status at BASE+4.
REQ-002 SHALL have parameter TIMEOUT, default 16'd4096: maximum busy polls before abort.
REQ-003 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1  transfer request per requester.
REQ-006 SHALL have ports tx0/tx1  input  32  word to transmit per requester.
REQ-007 SHALL have ports cs0/cs1  input  2  chip-select index per requester.
REQ-008 SHALL have port ack  output  2  one-cycle completion pulse, bit n for requester n.
REQ-009 SHALL have port err  output  1  coincident with ack, set when the transfer aborted on timeout.
REQ-010 SHALL have port rx_data  output  32  received word, valid while ack is high.
REQ-011 SHALL have ports m_w_addr, m_w_line  output  32; m_w  output  1: write side of the SPI master peripheral bus.
REQ-012 SHALL have ports m_r_addr  output  32; m_r  output  1; m_r_line  input  32: read side; m_r_line valid the cycle after m_r.
REQ-013 SHALL have port cs_n  output  4  active-low slave selects.

Function
REQ-014 SHALL use FSM states IDLE, SETUP, LOAD, POLL_REQ, POLL_WAIT, RD_REQ, RD_WAIT, ABORT, DONE.
REQ-015 SHALL in IDLE grant round-robin: a single request wins; with both requests high, the requester not served last wins.
REQ-016 SHALL latch tx and cs of the winner on grant and move to SETUP; the latched values are unaffected by later input changes.
REQ-017 SHALL in SETUP pulse m_w with m_w_addr=BASE+4, m_w_line=32'h1 (enable), then go to LOAD.
REQ-018 SHALL in LOAD pulse m_w with m_w_addr=BASE+0, m_w_line=latched tx, then go to POLL_REQ.
REQ-019 SHALL in POLL_REQ pulse m_r with m_r_addr=BASE+4, then go to POLL_WAIT.
REQ-020 SHALL in POLL_WAIT sample m_r_line[1] (busy): 1 -> increment poll counter, go to POLL_REQ; 0 -> go to RD_REQ.
REQ-021 SHALL go to ABORT instead of POLL_REQ when the poll counter reaches TIMEOUT; ABORT pulses m_w to BASE+4 with 32'h0 and goes to DONE with err set and rx_data 0.
REQ-022 SHALL in RD_REQ pulse m_r with m_r_addr=BASE+0; in RD_WAIT capture m_r_line into rx_data; then go to DONE.
REQ-023 SHALL in DONE pulse ack[granted] for exactly one cycle, record the granted requester as last-served, clear the poll counter and go to IDLE.
REQ-024 SHALL drive cs_n[latched cs] low from SETUP through DONE inclusive, all other cs_n bits high; cs_n=4'hF in IDLE.
REQ-025 SHALL produce ack 7 cycles after grant when the first poll reads busy=0 (grant cycle 0, ack in cycle 7).
REQ-026 SHALL ignore req deassertion mid-transfer; the transfer completes and ack still pulses.
REQ-027 SHALL treat req still high in the IDLE cycle after DONE as a new request.
REQ-028 SHALL hold m_w, m_r at 0 and all address/line outputs at 0 outside their strobe cycles.

Reset
REQ-029 SHALL on rst force state IDLE, ack=0, err=0, rx_data=0, m_w=m_r=0, address/line outputs 0, cs_n=4'hF, poll counter 0, last-served=requester 1 (so requester 0 wins the first tie).
REQ-030 SHALL on rst mid-transfer abandon the transfer immediately (cs_n high asynchronously) without issuing ack.

Structure
REQ-031 SHALL take register offsets (DATA=0, CTRL=4), control bit positions (ENABLE=0, BUSY=1) and the state encoding from shared package spi_pkg.
REQ-032 SHALL instantiate one sub-module rr_arbiter2 (2-way round-robin, grant plus last-served pointer); everything else is flat.

Verification
REQ-033 SHALL test: req0=1, tx0=32'hA5A5_0001, cs0=2, busy=0 on first poll -> writes CTRL=1 then DATA=A5A5_0001, cs_n=4'b1011, ack=2'b01 at cycle 7, rx_data = model data.
REQ-034 SHALL test: req0 and req1 high together from reset -> requester 0 served first, requester 1 next; repeating the tie alternates grants.
REQ-035 SHALL test: busy held 1 for 5 polls -> exactly 6 CTRL reads, ack 10 cycles later than REQ-033 case, err=0.
REQ-036 SHALL test: busy stuck 1 with TIMEOUT=8 -> 8 polls, CTRL written 0, ack with err=1, rx_data=0.
REQ-037 SHALL test: rst asserted during POLL_WAIT -> cs_n=4'hF same cycle, no ack, next req0 completes normally.
REQ-038 SHALL test: req1 dropped after grant -> transfer completes, ack=2'b10 pulses once.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared register map, control bit positions, FSM encoding and bus payload
// for the SPI master front-end arbiter.
package spi_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CS_W   = 2;
  localparam int unsigned NUM_CS = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [DATA_W-1:0] DATA_OFF = 32'h0000_0000;
  localparam logic [DATA_W-1:0] CTRL_OFF = 32'h0000_0004;

  localparam int unsigned ENABLE_BIT = 0;
  localparam int unsigned BUSY_BIT   = 1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SETUP     = 4'd1,
    LOAD      = 4'd2,
    POLL_REQ  = 4'd3,
    POLL_WAIT = 4'd4,
    RD_REQ    = 4'd5,
    RD_WAIT   = 4'd6,
    ABORT     = 4'd7,
    DONE      = 4'd8
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] line;
  } bus_t;

  // One-cold slave select for a chip-select index.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] one;
    one = NUM_CS'(1);
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-served pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       grant_valid_c,
  output logic       grant_idx_c
);

  logic last;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid_c = |req;
    grant_idx_c   = 1'b0;
    if (req == 2'b11) begin
      grant_idx_c = ~last;
    end else if (req[1]) begin
      grant_idx_c = 1'b1;
    end
  end

  // Reset to requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= served;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates two requesters onto one memory-mapped SPI master: enable, load,
// poll busy with timeout, read back, then acknowledge the granted requester.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h0000_1000,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] tx0,
  input  logic [31:0] tx1,
  input  logic [1:0]  cs0,
  input  logic [1:0]  cs1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rx_data,
  output logic [31:0] m_w_addr,
  output logic [31:0] m_w_line,
  output logic        m_w,
  output logic [31:0] m_r_addr,
  output logic        m_r,
  input  logic [31:0] m_r_line,
  output logic [3:0]  cs_n
);

  localparam logic [DATA_W-1:0] ENABLE_WORD = DATA_W'(1) << ENABLE_BIT;

  state_t            state, state_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic [CNT_W-1:0]  poll_cnt, poll_cnt_d;
  logic              aborted, aborted_d;

  logic [1:0]        ack_d;
  logic              err_d;
  logic [DATA_W-1:0] rx_d;
  logic              m_w_d, m_r_d;
  bus_t              wr_d;
  logic [DATA_W-1:0] m_r_addr_d;
  logic [NUM_CS-1:0] cs_n_d;

  logic              grant_valid_c;
  logic              grant_idx_c;

  rr_arbiter2 u_rr (
    .clk           (clk),
    .rst           (rst),
    .req           ({req1, req0}),
    .update        (state == DONE),
    .served        (sel_q),
    .grant_valid_c (grant_valid_c),
    .grant_idx_c   (grant_idx_c)
  );

  // State, latched transfer context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 1'b0;
      tx_q     <= '0;
      cs_q     <= '0;
      poll_cnt <= '0;
      aborted  <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      rx_data  <= '0;
      m_w      <= 1'b0;
      m_w_addr <= '0;
      m_w_line <= '0;
      m_r      <= 1'b0;
      m_r_addr <= '0;
      cs_n     <= '1;
    end else begin
      state    <= state_d;
      sel_q    <= sel_d;
      tx_q     <= tx_d;
      cs_q     <= cs_d;
      poll_cnt <= poll_cnt_d;
      aborted  <= aborted_d;
      ack      <= ack_d;
      err      <= err_d;
      rx_data  <= rx_d;
      m_w      <= m_w_d;
      m_w_addr <= wr_d.addr;
      m_w_line <= wr_d.line;
      m_r      <= m_r_d;
      m_r_addr <= m_r_addr_d;
      cs_n     <= cs_n_d;
    end
  end

  // Next state, then outputs decoded from the next state so each strobe
  // is registered yet lands in the cycle its state occupies.
  always_comb begin
    state_d    = state;
    sel_d      = sel_q;
    tx_d       = tx_q;
    cs_d       = cs_q;
    poll_cnt_d = poll_cnt;
    aborted_d  = aborted;
    rx_d       = rx_data;
    ack_d      = '0;
    err_d      = 1'b0;
    m_w_d      = 1'b0;
    wr_d       = '0;
    m_r_d      = 1'b0;
    m_r_addr_d = '0;
    cs_n_d     = '1;

    unique case (state)
      IDLE: begin
        if (grant_valid_c) begin
          state_d   = SETUP;
          sel_d     = grant_idx_c;
          tx_d      = grant_idx_c ? tx1 : tx0;
          cs_d      = grant_idx_c ? cs1 : cs0;
          aborted_d = 1'b0;
        end
      end
      SETUP:    state_d = LOAD;
      LOAD:     state_d = POLL_REQ;
      POLL_REQ: state_d = POLL_WAIT;
      POLL_WAIT: begin
        if (m_r_line[BUSY_BIT]) begin
          poll_cnt_d = poll_cnt + CNT_W'(1);
          state_d    = (poll_cnt_d == TIMEOUT) ? ABORT : POLL_REQ;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_REQ:   state_d = RD_WAIT;
      RD_WAIT: begin
        rx_d    = m_r_line;
        state_d = DONE;
      end
      ABORT: begin
        rx_d      = '0;
        aborted_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        poll_cnt_d = '0;
        state_d    = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    unique case (state_d)
      SETUP: begin
        m_w_d = 1'b1;
        wr_d  = '{addr: BASE + CTRL_OFF, line: ENABLE_WORD};
      end
      LOAD: begin
        m_w_d = 1'b1;
        wr_d  = '{addr: BASE + DATA_OFF, line: tx_d};
      end
      POLL_REQ: begin
        m_r_d      = 1'b1;
        m_r_addr_d = BASE + CTRL_OFF;
      end
      RD_REQ: begin
        m_r_d      = 1'b1;
        m_r_addr_d = BASE + DATA_OFF;
      end
      ABORT: begin
        m_w_d = 1'b1;
        wr_d  = '{addr: BASE + CTRL_OFF, line: '0};
      end
      DONE: begin
        ack_d = sel_d ? 2'b10 : 2'b01;
        err_d = aborted_d;
      end
      default: ;
    endcase

    if (state_d != IDLE) begin
      cs_n_d = cs_decode(cs_d);
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed table, hand sequences for
// reset/back-to-back, and random transfers against a transaction-level model.
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] TMO  = 16'd8;
  localparam int          T    = 8;

  logic        clk, rst;
  logic        req0, req1;
  logic [31:0] tx0, tx1;
  logic [1:0]  cs0, cs1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rx_data, m_w_addr, m_w_line, m_r_addr, m_r_line;
  logic        m_w, m_r;
  logic [3:0]  cs_n;

  int errors = 0;
  int checks = 0;

  spi_arbiter #(.BASE(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .tx0(tx0), .tx1(tx1),
    .cs0(cs0), .cs1(cs1), .ack(ack), .err(err), .rx_data(rx_data),
    .m_w_addr(m_w_addr), .m_w_line(m_w_line), .m_w(m_w),
    .m_r_addr(m_r_addr), .m_r(m_r), .m_r_line(m_r_line), .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Peripheral model: busy for the first busy_n polls after each enable write.
  int          polls = 0;
  int          busy_n = 0;
  logic [31:0] rd_word = '0;
  always @(posedge clk) begin
    if (m_w && m_w_addr == BASE + 32'h4 && m_w_line == 32'h1) polls <= 0;
    if (m_r && m_r_addr == BASE + 32'h4) begin
      m_r_line <= {30'h0, (polls < busy_n), 1'b1};
      polls    <= polls + 1;
    end else if (m_r && m_r_addr == BASE) begin
      m_r_line <= rd_word;
    end else begin
      m_r_line <= $urandom;
    end
  end

  // Bus monitor.
  logic [63:0] wlog[$];
  int ctrl_reads = 0, data_reads = 0, idle_viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_w) wlog.push_back({m_w_addr, m_w_line});
      if (m_r && m_r_addr == BASE + 32'h4) ctrl_reads++;
      if (m_r && m_r_addr == BASE) data_reads++;
      if (!m_w && (m_w_addr != 0 || m_w_line != 0)) idle_viol++;
      if (!m_r && m_r_addr != 0) idle_viol++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    int          lat;
    logic [3:0]  csn;
    logic [31:0] rx;
  } exp_t;

  typedef struct {
    logic        r0, r1;
    logic [31:0] t0, t1;
    logic [1:0]  c0, c1;
    int          busy;
    logic [31:0] rdw;
    exp_t        e;
  } vec_t;

  bit last_m = 1'b1;

  // Transaction-level expectation from arbitration and protocol rules.
  function automatic exp_t predict(input vec_t v, input bit last);
    exp_t       e;
    bit         w, ab;
    logic [3:0] one;
    one   = 4'b0001;
    w     = (v.r0 && v.r1) ? ~last : (v.r1 && !v.r0);
    ab    = (v.busy >= T);
    e.ack = w ? 2'b10 : 2'b01;
    e.err = ab;
    e.lat = ab ? 4 + 2 * T : 7 + 2 * v.busy;
    e.csn = ~(one << (w ? v.c1 : v.c0));
    e.rx  = ab ? 32'h0 : v.rdw;
    return e;
  endfunction

  function automatic vec_t mk(input logic r0, r1, input logic [31:0] t0, t1,
                              input logic [1:0] c0, c1, input int busy,
                              input logic [31:0] rdw, input logic [1:0] eack,
                              input logic eerr, input int elat,
                              input logic [3:0] ecsn, input logic [31:0] erx);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.t0 = t0; v.t1 = t1; v.c0 = c0; v.c1 = c1;
    v.busy = busy; v.rdw = rdw;
    v.e.ack = eack; v.e.err = eerr; v.e.lat = elat; v.e.csn = ecsn; v.e.rx = erx;
    return v;
  endfunction

  task automatic run_txn(input string nm, input vec_t v);
    exp_t        e = v.e;
    bit          w = e.ack[1];
    int          wsz0 = wlog.size();
    int          cr0 = ctrl_reads, dr0 = data_reads, iv0 = idle_viol;
    logic [1:0]  a = '0;
    logic        er = 1'b0;
    logic [31:0] rx = '0;
    int          lat = 0, csbad = 0, nw;
    logic [31:0] txw = w ? v.t1 : v.t0;
    busy_n = v.busy; rd_word = v.rdw;
    req0 = v.r0; req1 = v.r1; tx0 = v.t0; tx1 = v.t1; cs0 = v.c0; cs1 = v.c1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req0 = 1'b0; req1 = 1'b0;
        tx0 = $urandom; tx1 = $urandom; cs0 = 2'($urandom); cs1 = 2'($urandom);
      end
      if (cs_n !== e.csn) csbad++;
      if (ack !== 2'b00) begin
        a = ack; er = err; rx = rx_data; lat = k;
        break;
      end
    end
    chk({nm, " latency"}, 64'(lat), 64'(e.lat));
    chk({nm, " ack"}, 64'(a), 64'(e.ack));
    chk({nm, " err"}, 64'(er), 64'(e.err));
    chk({nm, " rx_data"}, 64'(rx), 64'(e.rx));
    chk({nm, " cs_n during transfer bad cycles"}, 64'(csbad), 64'(0));
    @(negedge clk);
    chk({nm, " ack single pulse"}, 64'(ack), 64'(0));
    chk({nm, " cs_n idle"}, 64'(cs_n), 64'hF);
    nw = e.err ? 3 : 2;
    chk({nm, " write count"}, 64'(wlog.size() - wsz0), 64'(nw));
    if (wlog.size() - wsz0 >= 2) begin
      chk({nm, " write ctrl enable"}, wlog[wsz0], {BASE + 32'h4, 32'h1});
      chk({nm, " write data"}, wlog[wsz0 + 1], {BASE, txw});
      if (e.err && wlog.size() - wsz0 >= 3)
        chk({nm, " write ctrl clear"}, wlog[wsz0 + 2], {BASE + 32'h4, 32'h0});
    end
    chk({nm, " ctrl reads"}, 64'(ctrl_reads - cr0), 64'(e.err ? T : v.busy + 1));
    chk({nm, " data reads"}, 64'(data_reads - dr0), 64'(e.err ? 0 : 1));
    chk({nm, " idle strobe leakage"}, 64'(idle_viol - iv0), 64'(0));
    last_m = w;
  endtask

  vec_t tbl[8];
  vec_t v;
  int   k1, k2;

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; tx0 = 0; tx1 = 0; cs0 = 0; cs1 = 0;
    tbl[0] = mk(1, 1, 32'hA5A5_0001, 32'hB0B0_0002, 2, 1, 0, 32'h1111_0000, 2'b01, 0, 7, 4'b1011, 32'h1111_0000);
    tbl[1] = mk(1, 1, 32'hA5A5_0001, 32'hB0B0_0002, 2, 1, 0, 32'h2222_0000, 2'b10, 0, 7, 4'b1101, 32'h2222_0000);
    tbl[2] = mk(1, 1, 32'hA5A5_0001, 32'hB0B0_0002, 2, 1, 0, 32'h3333_0000, 2'b01, 0, 7, 4'b1011, 32'h3333_0000);
    tbl[3] = mk(1, 0, 32'hA5A5_0001, 32'h0, 2, 0, 0, 32'h5A5A_1234, 2'b01, 0, 7, 4'b1011, 32'h5A5A_1234);
    tbl[4] = mk(1, 0, 32'h0000_0005, 32'h0, 0, 0, 5, 32'hCAFE_0005, 2'b01, 0, 17, 4'b1110, 32'hCAFE_0005);
    tbl[5] = mk(0, 1, 32'h0, 32'hDEAD_0006, 0, 3, 20, 32'h9999_9999, 2'b10, 1, 20, 4'b0111, 32'h0);
    tbl[6] = mk(0, 1, 32'h0, 32'hBEEF_0007, 0, 1, 7, 32'hBEEF_0007, 2'b10, 0, 21, 4'b1101, 32'hBEEF_0007);
    tbl[7] = mk(1, 0, 32'h1234_0008, 32'h0, 2, 0, 8, 32'h7777_7777, 2'b01, 1, 20, 4'b1011, 32'h0);

    repeat (3) @(negedge clk);
    chk("reset ack", 64'(ack), 0);
    chk("reset err", 64'(err), 0);
    chk("reset rx_data", 64'(rx_data), 0);
    chk("reset strobes", 64'({m_w, m_r}), 0);
    chk("reset addr/line", {m_w_addr | m_w_line, m_r_addr}, 0);
    chk("reset cs_n", 64'(cs_n), 64'hF);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset during POLL_WAIT abandons the transfer.
    busy_n = 5; req0 = 1; tx0 = 32'h0BAD_0BAD; cs0 = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req0 = 0;
    end
    chk("pre-reset cs_n", 64'(cs_n), 64'b1101);
    rst = 1'b1;
    #1;
    chk("async reset cs_n", 64'(cs_n), 64'hF);
    chk("async reset ack", 64'(ack), 0);
    k1 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack !== 2'b00) k1++;
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack !== 2'b00) k1++;
    end
    chk("no ack after reset", 64'(k1), 0);
    last_m = 1'b1;
    v = mk(1, 0, 32'h600D_0001, 32'h0, 3, 0, 1, 32'h4242_4242, 0, 0, 0, 0, 0);
    v.e = predict(v, last_m);
    run_txn("post-reset", v);

    // Request held through DONE is granted again in the following IDLE cycle.
    busy_n = 0; rd_word = 32'h0101_0101; req0 = 1; req1 = 0; tx0 = 32'h55; cs0 = 0;
    k1 = 0; k2 = 0;
    for (int k = 1; k <= 60 && k2 == 0; k++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        if (k1 == 0) k1 = k;
        else begin k2 = k; req0 = 0; end
      end
    end
    chk("held req first ack", 64'(k1), 64'(7));
    chk("held req regrant gap", 64'(k2 - k1), 64'(8));
    @(negedge clk);
    last_m = 1'b0;

    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(1, 3);
      v.r0 = r[0]; v.r1 = r[1];
      v.t0 = $urandom; v.t1 = $urandom;
      v.c0 = 2'($urandom); v.c1 = 2'($urandom);
      v.busy = $urandom_range(0, 10);
      v.rdw = $urandom;
      v.e = predict(v, last_m);
      run_txn($sformatf("rand%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
